// File: rtl/load_sequencer.sv
// RV32I load sequencer: aligns, extends and optionally splits misaligned loads
// across two word reads. Optional feature macro: MISALIGN_SPLIT_EN.
module load_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_re,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  // state  | meaning
  // IDLE   | ready for a request; accept cycle issues the first word read
  // FIT    | response cycle for single-word or illegal loads
  // SPLIT0 | first word returned; issue the read of the following word
  // SPLIT1 | second word returned; response cycle for split loads
  typedef enum logic [1:0] {IDLE, FIT, SPLIT0, SPLIT1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      sft_q, sft_d;
  logic            err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]   lo_buf_q, lo_buf_d;
  logic [2*XLEN-1:0] split_shifted;
`endif

  logic            illegal_in, split_in;
  logic [XLEN-1:0] fit_shifted;

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      2'd0:    r = {{(XLEN-8){w[7] & ~f3[2]}}, w[7:0]};
      2'd1:    r = {{(XLEN-16){w[15] & ~f3[2]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    illegal_in = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    split_in   = ((req_funct3[1:0] == 2'd1) && (req_addr[1:0] == 2'd3)) ||
                 ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'd0));
  end

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    sft_d      = sft_q;
    err_d      = err_q;
`ifdef MISALIGN_SPLIT_EN
    waddr_d    = waddr_q;
    lo_buf_d   = lo_buf_q;
    split_shifted = {mem_rdata, lo_buf_q} >> {sft_q, 3'b000};
`endif
    fit_shifted = mem_rdata >> {sft_q, 3'b000};
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d = req_funct3;
          sft_d    = req_addr[1:0];
`ifdef MISALIGN_SPLIT_EN
          if (illegal_in) begin
`else
          // Without split support a misaligned word-crossing load is reported as an error.
          if (illegal_in || split_in) begin
`endif
            err_d   = 1'b1;
            state_d = FIT;
          end else begin
            err_d    = 1'b0;
            mem_re   = 1'b1;
            mem_addr = {req_addr[XLEN-1:2], 2'b00};
`ifdef MISALIGN_SPLIT_EN
            waddr_d  = {req_addr[XLEN-1:2], 2'b00};
            state_d  = split_in ? SPLIT0 : FIT;
`else
            state_d  = FIT;
`endif
          end
        end
      end
      FIT: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_data  = err_q ? '0 : extend(funct3_q, fit_shifted);
        state_d    = IDLE;
      end
`ifdef MISALIGN_SPLIT_EN
      SPLIT0: begin
        lo_buf_d = mem_rdata;
        mem_re   = 1'b1;
        mem_addr = waddr_q + XLEN'(4);
        state_d  = SPLIT1;
      end
      SPLIT1: begin
        resp_valid = 1'b1;
        resp_data  = extend(funct3_q, split_shifted[XLEN-1:0]);
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (rst) begin
      req_ready  = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = '0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      sft_q    <= '0;
      err_q    <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      waddr_q  <= '0;
      lo_buf_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      sft_q    <= sft_d;
      err_q    <= err_d;
`ifdef MISALIGN_SPLIT_EN
      waddr_q  <= waddr_d;
      lo_buf_q <= lo_buf_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer with a one-cycle-latency word memory model.
module tb_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  load_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h4433_2211;
      32'h0000_0104: return 32'h8877_6655;
      32'h0000_0108: return 32'h0000_CCBB;
      32'hFFFF_FFFC: return 32'hDDCC_BBAA;
      32'h0000_0000: return 32'h0000_0011;
      default:       return 32'h0;
    endcase
  endfunction

  // Data is only meaningful the cycle after a read; otherwise a poison value.
  always @(posedge clk) mem_rdata <= mem_re ? mem_word(mem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                         input int exp_nre, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int          nre = 0;
    int          lat = -1;
    int          bad_idle = 0;
    logic [31:0] ra0 = 32'h0;
    logic [31:0] ra1 = 32'h0;
    logic [31:0] rd = 32'h0;
    logic        re = 1'b0;
    logic        rdy_resp = 1'b1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f3;
    #1;
    check({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (cyc == 1) begin
          req_valid  = 1'b0;
          req_addr   = 32'h0000_0103;
          req_funct3 = 3'd0;
        end
        #1;
      end
      if (mem_re) begin
        if (nre == 0) ra0 = mem_addr; else ra1 = mem_addr;
        nre++;
      end
      if (resp_valid) begin
        if (lat < 0) begin
          lat = cyc; rd = resp_data; re = resp_err; rdy_resp = req_ready;
        end
      end else if (resp_data != 0 || resp_err) begin
        bad_idle++;
      end
    end
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":data"}, rd, exp_data);
    check({tag, ":err"}, {31'b0, re}, {31'b0, exp_err});
    check({tag, ":n_mem_re"}, nre, exp_nre);
    if (exp_nre > 0) check({tag, ":addr0"}, ra0, exp_a0);
    if (exp_nre > 1) check({tag, ":addr1"}, ra1, exp_a1);
    check({tag, ":ready_in_resp"}, {31'b0, rdy_resp}, 32'd0);
    check({tag, ":idle_outputs"}, bad_idle, 0);
  endtask

  initial begin
    int n_resp;
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0100;
    req_funct3 = 3'd2;
    repeat (2) @(negedge clk);
    #1;
    check("rst:ready", {31'b0, req_ready}, 32'd0);
    check("rst:mem_re", {31'b0, mem_re}, 32'd0);
    check("rst:mem_addr", mem_addr, 32'h0);
    check("rst:resp", {resp_data[30:0], resp_valid | resp_err}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_load("lw_100",  3'd2, 32'h0000_0100, 1, 32'h4433_2211, 1'b0, 1, 32'h100, 32'h0);
    do_load("lb_107",  3'd0, 32'h0000_0107, 1, 32'hFFFF_FF88, 1'b0, 1, 32'h104, 32'h0);
    do_load("lbu_107", 3'd4, 32'h0000_0107, 1, 32'h0000_0088, 1'b0, 1, 32'h104, 32'h0);
    do_load("lh_105",  3'd1, 32'h0000_0105, 1, 32'h0000_7766, 1'b0, 1, 32'h104, 32'h0);
    do_load("lhu_102", 3'd5, 32'h0000_0102, 1, 32'h0000_4433, 1'b0, 1, 32'h100, 32'h0);
    do_load("lb_100",  3'd0, 32'h0000_0100, 1, 32'h0000_0011, 1'b0, 1, 32'h100, 32'h0);
    do_load("f3_3",    3'd3, 32'h0000_0100, 1, 32'h0,         1'b1, 0, 32'h0,   32'h0);
    do_load("f3_7",    3'd7, 32'h0000_0104, 1, 32'h0,         1'b1, 0, 32'h0,   32'h0);
`ifdef MISALIGN_SPLIT_EN
    do_load("lw_102",  3'd2, 32'h0000_0102, 2, 32'h6655_4433, 1'b0, 2, 32'h100, 32'h104);
    do_load("lhu_107", 3'd5, 32'h0000_0107, 2, 32'h0000_BB88, 1'b0, 2, 32'h104, 32'h108);
    do_load("lh_103",  3'd1, 32'h0000_0103, 2, 32'h0000_5544, 1'b0, 2, 32'h100, 32'h104);
    do_load("lh_wrap", 3'd1, 32'hFFFF_FFFF, 2, 32'h0000_11DD, 1'b0, 2, 32'hFFFF_FFFC, 32'h0);
`else
    do_load("lw_102",  3'd2, 32'h0000_0102, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
    do_load("lh_wrap", 3'd1, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
`endif

    // Abort an in-flight misaligned word load with reset in its second cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0102;
    req_funct3 = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("abort:mem_re", {31'b0, mem_re}, 32'd0);
    check("abort:mem_addr", mem_addr, 32'h0);
    check("abort:resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort:ready", {31'b0, req_ready}, 32'd1);
    n_resp = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) n_resp++;
      @(negedge clk);
      #1;
    end
    check("abort:no_resp", n_resp, 0);
    do_load("lw_104", 3'd2, 32'h0000_0104, 1, 32'h8877_6655, 1'b0, 1, 32'h104, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
